pipelined_rv32_cpu: RTL and testbench
=====================================

Name: pipelined_rv32_cpu

Overview:
- 5-stage in-order RV32I-subset pipelined processor core (IF, ID, EX, MEM, WB) with embedded instruction memory, data memory and register file.
- Provides full EX-stage forwarding, load-use hazard stalling, and branch resolution in ID with a one-slot flush.
- Top-level compute block of the processor design; only clock, reset and start cross its boundary.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words (word-addressed by PC[9:2]).
- DMEM_WORDS, 32, data memory depth in 32-bit words (byte address [6:2]).

Ports:
- clk_i    input  1  system clock; all state updates on rising edge.
- rst_i    input  1  reset, asynchronous, active-low.
- start_i  input  1  run enable; PC advances only while high.

Behaviour:
- Reset (rst_i low, async): PC=0; all pipeline registers IF/ID, ID/EX, EX/MEM, MEM/WB cleared (behaves as NOP, RegWrite/MemWrite/MemRead=0). Register file and memories are not cleared. Reset mid-run discards all in-flight instructions.
- start_i low: PC holds. Pipeline registers keep clocking, so in-flight work drains.
- Instruction set:
  - R-type: and, xor, sll, add, sub, mul (low 32 bits).
  - I-type: addi, srai (shamt=imm[4:0], arithmetic).
  - Memory: lw, sw.
  - Branch: beq.
  - Unknown opcode and all-zero word execute as NOP (no writes).
- Register file: 32x32, x0 reads 0, writes to x0 are ignored. Write occurs in WB on the rising edge. A same-cycle read of the register being written returns the new value (internal bypass).
- Immediates are sign-extended to 32 bits. Branch offset = {imm[12:1],0}.
- Forwarding into EX ALU operands:
  - EX/MEM result has priority when EX/MEM.RegWrite, rd!=0 and rd==rs.
  - Otherwise MEM/WB result (load data or ALU result) under the same conditions.
  - sw store data uses the forwarded rs2.
- Load-use stall: when ID/EX.MemRead and ID/EX.rd matches the ID rs1 or rs2 (rd!=0):
  - PC and IF/ID hold.
  - A bubble (all control zero) is inserted into ID/EX.
  - Lasts exactly 1 cycle.
- beq:
  - Compared in ID using register-file read values; no forwarding into ID.
  - Taken: next PC = IF/ID.pc + offset, and IF/ID is flushed to NOP, giving exactly 1 wasted cycle.
  - Not taken: PC+4.
  - If a load-use stall and a branch occur in the same cycle, the stall wins and the branch re-evaluates next cycle.
- Data memory: word access, synchronous write on the clock edge in MEM, combinational read. Addresses beyond DMEM_WORDS wrap modulo depth.
- PC wraps at IMEM_WORDS*4.
- Verification observability (hierarchical names, required):
  - PC.pc_o
  - Registers.register[0:31]
  - Instruction_Memory.memory[]
  - Data_Memory.memory[]
  - Hazard_Detection.Stall_o
  - Control.Branch_o
  - top-level wire Flush
- Stall count = cycles with Stall_o=1 and Branch_o=0. Flush count = cycles with Flush=1.

Test Plan:
- Reset/start: rst_i low then high, start_i=1, all-zero imem -> PC increments by 4 per cycle (0,4,8,...). No register or memory changes.
- Load + use: dmem[0..4]=5,6,10,18,29. Program `lw x1,0(x0)`; `add x2,x1,x1` -> exactly 1 stall, x1=5, x2=10.
- Forwarding: `addi x3,x0,7`; `sub x4,x3,x24` (x24=-24); `mul x5,x4,x3` -> x4=31, x5=217, zero stalls.
- Store/srai: `sw x28,20(x0)` (x28=56); `srai x6,x27,1` (x27=-27) -> dmem[5]=56, x6=-14.
- Taken beq: `beq x0,x0,+8` followed by `addi x7,x0,1`; `addi x8,x0,2` -> flush count 1, x7=0, x8=2.
- Mid-run reset: assert rst_i low during execution -> PC=0 immediately (asynchronously), no write from in-flight instructions, restart re-executes from address 0.

Source files
------------

// File: rtl/pipelined_rv32_cpu.sv
// Five-stage RV32I-subset core with forwarding, load-use stall
// and ID-stage beq resolution; memories and register file inside.
package rv32_pkg;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR,
    ALU_SLL, ALU_SRA, ALU_MUL
  } alu_op_t;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    alu_op_t     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] store;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
  } mem_wb_t;
endpackage

module pc_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] next,
  output logic [31:0] pc_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_o <= '0;
    else if (en) pc_o <= next;
endmodule

module ram #(
  parameter int WORDS = 32,
  parameter int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] memory [0:WORDS-1];

  always_ff @(posedge clk)
    if (we) memory[addr] <= wdata;

  assign rdata = memory[addr];
endmodule

module reg_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] register [0:31];

  always_ff @(posedge clk)
    if (we && wa != 5'd0) register[wa] <= wd;

  // WB value is visible to ID in the same cycle
  assign rd1 = (ra1 == 5'd0) ? '0 :
               (we && wa == ra1) ? wd : register[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 :
               (we && wa == ra2) ? wd : register[ra2];
endmodule

module hazard_unit (
  input  logic       mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       Stall_o
);
  assign Stall_o = mem_read && ex_rd != 5'd0 &&
                   (ex_rd == rs1 || ex_rd == rs2);
endmodule

module control_unit
  import rv32_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       Branch_o,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output alu_op_t    alu_op,
  output logic [1:0] imm_sel
);
  logic r_op;
  logic i_op;

  assign r_op = opcode == 7'h33;
  assign i_op = opcode == 7'h13;

  always_comb begin
    Branch_o  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    imm_sel   = IMM_I;
    unique case (1'b1)
      r_op && funct3 == 3'd0 && funct7 == 7'h00:
        reg_write = 1'b1;
      r_op && funct3 == 3'd0 && funct7 == 7'h20: begin
        reg_write = 1'b1;
        alu_op    = ALU_SUB;
      end
      r_op && funct3 == 3'd0 && funct7 == 7'h01: begin
        reg_write = 1'b1;
        alu_op    = ALU_MUL;
      end
      r_op && funct3 == 3'd1 && funct7 == 7'h00: begin
        reg_write = 1'b1;
        alu_op    = ALU_SLL;
      end
      r_op && funct3 == 3'd4 && funct7 == 7'h00: begin
        reg_write = 1'b1;
        alu_op    = ALU_XOR;
      end
      r_op && funct3 == 3'd7 && funct7 == 7'h00: begin
        reg_write = 1'b1;
        alu_op    = ALU_AND;
      end
      i_op && funct3 == 3'd0: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      i_op && funct3 == 3'd5 && funct7 == 7'h20: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALU_SRA;
      end
      opcode == 7'h03 && funct3 == 3'd2: begin
        reg_write = 1'b1;
        mem_read  = 1'b1;
        alu_src   = 1'b1;
      end
      opcode == 7'h23 && funct3 == 3'd2: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_sel   = IMM_S;
      end
      opcode == 7'h63 && funct3 == 3'd0: begin
        Branch_o = 1'b1;
        imm_sel  = IMM_B;
      end
      default: ;
    endcase
  end
endmodule

module pipelined_rv32_cpu
  import rv32_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 32
) (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

  logic [31:0] pc, pc_next, instr;
  if_id_t      if_id;
  id_ex_t      id_ex;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic        stall, Flush, branch;
  logic        reg_write, mem_read, mem_write, alu_src;
  alu_op_t     alu_op;
  logic [1:0]  imm_sel;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rd1, rd2, imm;
  logic [31:0] fwd_a, fwd_b, op_b, alu, dmem_rdata;
  logic        unused;

  assign rs1 = if_id.instr[19:15];
  assign rs2 = if_id.instr[24:20];
  assign rd  = if_id.instr[11:7];

  assign Flush   = branch && !stall && rd1 == rd2;
  assign pc_next = (Flush ? if_id.pc + imm : pc + 32'd4)
                 & PC_MASK;

  pc_reg PC (
    .clk  (clk_i),
    .rst_n(rst_i),
    .en   (start_i && !stall),
    .next (pc_next),
    .pc_o (pc)
  );

  ram #(.WORDS(IMEM_WORDS)) Instruction_Memory (
    .clk  (clk_i),
    .we   (1'b0),
    .addr (pc[IAW+1:2]),
    .wdata(32'd0),
    .rdata(instr)
  );

  // With start low nothing new enters, so the pipe drains
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) if_id <= '0;
    else if (!stall)
      if_id <= (Flush || !start_i) ? '0 : {pc, instr};

  control_unit Control (
    .opcode   (if_id.instr[6:0]),
    .funct3   (if_id.instr[14:12]),
    .funct7   (if_id.instr[31:25]),
    .Branch_o (branch),
    .reg_write(reg_write),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .alu_src  (alu_src),
    .alu_op   (alu_op),
    .imm_sel  (imm_sel)
  );

  hazard_unit Hazard_Detection (
    .mem_read(id_ex.mem_read),
    .ex_rd   (id_ex.rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .Stall_o (stall)
  );

  reg_file Registers (
    .clk(clk_i),
    .we (mem_wb.reg_write),
    .wa (mem_wb.rd),
    .wd (mem_wb.data),
    .ra1(rs1),
    .ra2(rs2),
    .rd1(rd1),
    .rd2(rd2)
  );

  always_comb begin
    imm = {{20{if_id.instr[31]}}, if_id.instr[31:20]};
    case (imm_sel)
      IMM_S: imm = {{20{if_id.instr[31]}},
                    if_id.instr[31:25], if_id.instr[11:7]};
      IMM_B: imm = {{19{if_id.instr[31]}}, if_id.instr[31],
                    if_id.instr[7], if_id.instr[30:25],
                    if_id.instr[11:8], 1'b0};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i || stall) id_ex <= '0;
    else begin
      id_ex.reg_write <= reg_write;
      id_ex.mem_read  <= mem_read;
      id_ex.mem_write <= mem_write;
      id_ex.alu_src   <= alu_src;
      id_ex.alu_op    <= alu_op;
      id_ex.rs1       <= rs1;
      id_ex.rs2       <= rs2;
      id_ex.rd        <= rd;
      id_ex.a         <= rd1;
      id_ex.b         <= rd2;
      id_ex.imm       <= imm;
    end

  always_comb begin
    fwd_a = id_ex.a;
    if (ex_mem.reg_write && ex_mem.rd != 5'd0 &&
        ex_mem.rd == id_ex.rs1)
      fwd_a = ex_mem.alu;
    else if (mem_wb.reg_write && mem_wb.rd != 5'd0 &&
             mem_wb.rd == id_ex.rs1)
      fwd_a = mem_wb.data;
    fwd_b = id_ex.b;
    if (ex_mem.reg_write && ex_mem.rd != 5'd0 &&
        ex_mem.rd == id_ex.rs2)
      fwd_b = ex_mem.alu;
    else if (mem_wb.reg_write && mem_wb.rd != 5'd0 &&
             mem_wb.rd == id_ex.rs2)
      fwd_b = mem_wb.data;
  end

  always_comb begin
    op_b = id_ex.alu_src ? id_ex.imm : fwd_b;
    case (id_ex.alu_op)
      ALU_ADD: alu = fwd_a + op_b;
      ALU_SUB: alu = fwd_a - op_b;
      ALU_AND: alu = fwd_a & op_b;
      ALU_XOR: alu = fwd_a ^ op_b;
      ALU_SLL: alu = fwd_a << op_b[4:0];
      ALU_SRA: alu = $signed(fwd_a) >>> op_b[4:0];
      ALU_MUL: alu = fwd_a * op_b;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) ex_mem <= '0;
    else begin
      ex_mem.reg_write <= id_ex.reg_write;
      ex_mem.mem_read  <= id_ex.mem_read;
      ex_mem.mem_write <= id_ex.mem_write;
      ex_mem.rd        <= id_ex.rd;
      ex_mem.alu       <= alu;
      ex_mem.store     <= fwd_b;
    end

  ram #(.WORDS(DMEM_WORDS)) Data_Memory (
    .clk  (clk_i),
    .we   (ex_mem.mem_write),
    .addr (ex_mem.alu[DAW+1:2]),
    .wdata(ex_mem.store),
    .rdata(dmem_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) mem_wb <= '0;
    else begin
      mem_wb.reg_write <= ex_mem.reg_write;
      mem_wb.rd        <= ex_mem.rd;
      mem_wb.data      <= ex_mem.mem_read ? dmem_rdata
                                          : ex_mem.alu;
    end

  assign unused = ^{pc[31:IAW+2], pc[1:0],
                    ex_mem.alu[31:DAW+2], ex_mem.alu[1:0]};
endmodule

// File: tb/tb_pipelined_rv32_cpu.sv
// Bench for pipelined_rv32_cpu: directed programs plus random
// straight-line programs checked against an ISA-level model.
module tb_pipelined_rv32_cpu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int stalls, flushes;

  pipelined_rv32_cpu #(
    .IMEM_WORDS(256),
    .DMEM_WORDS(32)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start)
  );

  always #5 clk = ~clk;

  typedef enum {
    K_ADD, K_SUB, K_AND, K_XOR, K_SLL,
    K_MUL, K_ADDI, K_SRAI, K_LW, K_SW, K_BEQ
  } kind_t;

  typedef struct {
    kind_t       kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } op_t;

  logic [31:0] m_reg [32];
  logic [31:0] m_mem [32];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(kind_t k, int rd, int rs1,
                             int rs2, int imm);
    op_t o;
    o.kind = k;
    o.rd   = 5'(rd);
    o.rs1  = 5'(rs1);
    o.rs2  = 5'(rs2);
    o.imm  = 32'(imm);
    return o;
  endfunction

  function automatic logic [31:0] enc(op_t o);
    logic [31:0] i;
    i = o.imm;
    case (o.kind)
      K_ADD: return {7'h00, o.rs2, o.rs1, 3'd0, o.rd, 7'h33};
      K_SUB: return {7'h20, o.rs2, o.rs1, 3'd0, o.rd, 7'h33};
      K_MUL: return {7'h01, o.rs2, o.rs1, 3'd0, o.rd, 7'h33};
      K_SLL: return {7'h00, o.rs2, o.rs1, 3'd1, o.rd, 7'h33};
      K_XOR: return {7'h00, o.rs2, o.rs1, 3'd4, o.rd, 7'h33};
      K_AND: return {7'h00, o.rs2, o.rs1, 3'd7, o.rd, 7'h33};
      K_ADDI: return {i[11:0], o.rs1, 3'd0, o.rd, 7'h13};
      K_SRAI: return {7'h20, i[4:0], o.rs1, 3'd5, o.rd, 7'h13};
      K_LW: return {i[11:0], o.rs1, 3'd2, o.rd, 7'h03};
      K_SW: return {i[11:5], o.rs2, o.rs1, 3'd2, i[4:0], 7'h23};
      K_BEQ: return {i[12], i[10:5], o.rs2, o.rs1, 3'd0,
                     i[4:1], i[11], 7'h63};
      default: return 32'h0;
    endcase
  endfunction

  // ISA semantics, one instruction at a time
  task automatic model_exec(op_t o);
    logic [31:0] a, b, res;
    int idx;
    a = m_reg[o.rs1];
    b = m_reg[o.rs2];
    idx = int'(((a + o.imm) >> 2) % 32);
    res = 0;
    case (o.kind)
      K_ADD:  res = a + b;
      K_SUB:  res = a - b;
      K_AND:  res = a & b;
      K_XOR:  res = a ^ b;
      K_SLL:  res = a << (b % 32);
      K_MUL:  res = a * b;
      K_ADDI: res = a + o.imm;
      K_SRAI: res = $signed(a) >>> (o.imm % 32);
      K_LW:   res = m_mem[idx];
      K_SW:   m_mem[idx] = b;
      default: ;
    endcase
    if (o.kind != K_SW && o.rd != 0) m_reg[o.rd] = res;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++)
      dut.Instruction_Memory.memory[i] = 32'h0;
  endtask

  task automatic load(op_t p[$]);
    foreach (p[i]) dut.Instruction_Memory.memory[i] = enc(p[i]);
  endtask

  task automatic set_reg(int r, logic [31:0] v);
    dut.Registers.register[r] = v;
    m_reg[r] = v;
  endtask

  task automatic set_mem(int a, logic [31:0] v);
    dut.Data_Memory.memory[a] = v;
    m_mem[a] = v;
  endtask

  task automatic run(int cycles);
    stalls = 0;
    flushes = 0;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      if (dut.Hazard_Detection.Stall_o && !dut.Control.Branch_o)
        stalls++;
      if (dut.Flush) flushes++;
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [31:0] rf(int r);
    return dut.Registers.register[r];
  endfunction

  initial begin
    int dv[5] = '{5, 6, 10, 18, 29};
    op_t prog[$];
    logic [31:0] w[$];
    int exp_stalls;
    m_reg[0] = 0;

    // reset and free-running fetch over NOPs
    enter_reset();
    check("rst_pc", dut.PC.pc_o, 32'd0);
    check("rst_stall", 32'(dut.Hazard_Detection.Stall_o), 0);
    set_reg(5, 32'h1234);
    set_mem(3, 32'hABCD);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("pc_step%0d", k), dut.PC.pc_o, 32'(4 * k));
    end
    repeat (10) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("hold_pc", dut.PC.pc_o, 32'd60);
    check("nop_x5", rf(5), 32'h1234);
    check("nop_mem3", dut.Data_Memory.memory[3], 32'hABCD);

    // load followed by dependent add
    enter_reset();
    for (int i = 0; i < 5; i++) set_mem(i, 32'(dv[i]));
    prog = '{mk(K_LW, 1, 0, 0, 0), mk(K_ADD, 2, 1, 1, 0)};
    load(prog);
    run(14);
    check("lu_stalls", 32'(stalls), 32'd1);
    check("lu_x1", rf(1), 32'd5);
    check("lu_x2", rf(2), 32'd10);

    // back-to-back forwarding
    enter_reset();
    set_reg(24, -32'sd24);
    prog = '{mk(K_ADDI, 3, 0, 0, 7), mk(K_SUB, 4, 3, 24, 0),
             mk(K_MUL, 5, 4, 3, 0)};
    load(prog);
    run(14);
    check("fw_stalls", 32'(stalls), 32'd0);
    check("fw_x4", rf(4), 32'd31);
    check("fw_x5", rf(5), 32'd217);

    // store and arithmetic shift
    enter_reset();
    set_reg(28, 32'd56);
    set_reg(27, -32'sd27);
    prog = '{mk(K_SW, 0, 0, 28, 20), mk(K_SRAI, 6, 27, 0, 1)};
    load(prog);
    run(14);
    check("sw_mem5", dut.Data_Memory.memory[5], 32'd56);
    check("srai_x6", rf(6), 32'hFFFF_FFF2);

    // taken branch skips one slot
    enter_reset();
    set_reg(7, 32'd0);
    set_reg(8, 32'd0);
    prog = '{mk(K_BEQ, 0, 0, 0, 8), mk(K_ADDI, 7, 0, 0, 1),
             mk(K_ADDI, 8, 0, 0, 2)};
    load(prog);
    run(14);
    check("br_flushes", 32'(flushes), 32'd1);
    check("br_x7", rf(7), 32'd0);
    check("br_x8", rf(8), 32'd2);

    // reset while an instruction is in flight
    enter_reset();
    set_reg(9, 32'd100);
    prog = '{mk(K_ADDI, 9, 9, 0, 1)};
    load(prog);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_pc", dut.PC.pc_o, 32'd8);
    #2 rst = 1'b0;
    start = 1'b0;
    #1 check("async_pc", dut.PC.pc_o, 32'd0);
    repeat (4) @(negedge clk);
    check("discard_x9", rf(9), 32'd100);
    run(12);
    check("rerun_x9", rf(9), 32'd101);

    // random straight-line programs
    for (int it = 0; it < 6; it++) begin
      enter_reset();
      for (int r = 1; r < 32; r++) set_reg(r, $urandom);
      for (int a = 0; a < 32; a++) set_mem(a, $urandom);
      prog.delete();
      w.delete();
      for (int k = 0; k < 24; k++) begin
        op_t o;
        logic [11:0] r12;
        r12 = 12'($urandom);
        o = mk(kind_t'($urandom_range(0, 9)),
               int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), 0);
        if (o.kind == K_SRAI) o.imm = 32'($urandom_range(0, 31));
        else o.imm = {{20{r12[11]}}, r12};
        prog.push_back(o);
        w.push_back(enc(o));
      end
      exp_stalls = 0;
      for (int k = 1; k < 24; k++)
        if (prog[k-1].kind == K_LW && prog[k-1].rd != 0 &&
            (prog[k-1].rd == w[k][19:15] ||
             prog[k-1].rd == w[k][24:20]))
          exp_stalls++;
      foreach (prog[k]) model_exec(prog[k]);
      load(prog);
      run(58);
      check($sformatf("rnd%0d_stalls", it), 32'(stalls),
            32'(exp_stalls));
      check($sformatf("rnd%0d_flushes", it), 32'(flushes), 0);
      for (int r = 1; r < 32; r++)
        check($sformatf("rnd%0d_x%0d", it, r), rf(r), m_reg[r]);
      for (int a = 0; a < 32; a++)
        check($sformatf("rnd%0d_m%0d", it, a),
              dut.Data_Memory.memory[a], m_mem[a]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
